elevator_call_scheduler: RTL

//  Call bookkeeping and motion/door sequencing beside the elevator direction FSM.
//  - Latches floor calls; tracks car position with a per-floor travel timer.
//  - Times the door.
//  - Produces request_i / request_j_gt_i / request_j_lt_i and close for the FSM.
//  - Consumes the FSM's up/down/open. One instance per car.

---
 rtl/elevator_call_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Keeps the books for one elevator car and sequences its motion and door. It
// sits next to the direction FSM: this block reports where calls are pending
// relative to the car, and the FSM answers with up/down/open commands.
//
// The interface has no valid/ready handshake. The FSM's up/down/open are level
// commands that are looked at only while this block is IDLE. The request flags
// are derived only from registered state, so there is no combinational loop
// through the FSM.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   call_btn       in   per-floor call buttons (level, bit k = floor k)
//   up/down/open   in   FSM commands
//   close          out  1 = door closed (registered)
//   request_i      out  call pending at cur_floor and car stationary
//   request_j_gt_i out  call pending above cur_floor
//   request_j_lt_i out  call pending below cur_floor
//   cur_floor      out  current / last-passed floor (registered)
//   pending        out  latched calls (registered)
//   moving         out  1 while travelling between floors
//   fault          out  sticky illegal-command flag, cleared only by rst_n
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic                up,
  input  logic                down,
  input  logic                open,
  output logic                close,
  output logic                request_i,
  output logic                request_j_gt_i,
  output logic                request_j_lt_i,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                moving,
  output logic                fault
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]      DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  state_t              state;
  // One timer serves both travel and door timing; the states are exclusive.
  logic [TW-1:0]       timer;
  logic [N_FLOORS-1:0] pending_nxt;
  logic                call_at_cur;
  logic                pend_at_cur;
  logic                pend_above;
  logic                pend_below;
  logic                clear_cur;

  assign moving = (state == MOVE_UP) || (state == MOVE_DN);

  // The current floor's bit is held clear while the door opens and for as
  // long as it stays open; a press at the open door only restarts the timer.
  assign clear_cur = ((state == IDLE) && open) || (state == DOOR);

  always_comb begin
    pending_nxt = pending | call_btn;
    call_at_cur = 1'b0;
    pend_at_cur = 1'b0;
    pend_above  = 1'b0;
    pend_below  = 1'b0;
    for (int k = 0; k < N_FLOORS; k++) begin
      if (k == int'(cur_floor)) begin
        call_at_cur = call_btn[k];
        pend_at_cur = pending[k];
        if (clear_cur) pending_nxt[k] = 1'b0;
      end else if (k > int'(cur_floor)) begin
        if (pending[k]) pend_above = 1'b1;
      end else begin
        if (pending[k]) pend_below = 1'b1;
      end
    end
  end

  // Suppressed while moving so the FSM cannot open the door between floors.
  assign request_i      = pend_at_cur && !moving;
  assign request_j_gt_i = pend_above;
  assign request_j_lt_i = pend_below;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cur_floor <= '0;
      pending   <= '0;
      close     <= 1'b1;
      fault     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (open) begin
            state <= DOOR;
            close <= 1'b0;
            timer <= '0;
          end else if (up && down) begin
            fault <= 1'b1;
          end else if (up) begin
            if (cur_floor != TOP_FLOOR) begin
              state <= MOVE_UP;
              timer <= '0;
            end else begin
              fault <= 1'b1;
            end
          end else if (down) begin
            if (cur_floor != '0) begin
              state <= MOVE_DN;
              timer <= '0;
            end else begin
              fault <= 1'b1;
            end
          end
        end

        MOVE_UP, MOVE_DN: begin
          // Floor changes TRAVEL_CYCLES edges after the entry edge.
          if (timer == TRAVEL_LAST) begin
            if (state == MOVE_UP) cur_floor <= cur_floor + FLOOR_W'(1);
            else                  cur_floor <= cur_floor - FLOOR_W'(1);
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DOOR: begin
          if (call_at_cur) begin
            timer <= '0;
          end else if (timer == DOOR_LAST) begin
            close <= 1'b1;
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
